// File: rtl/mem_stage.sv
// Memory stage: drives the data bus and holds the pipeline while a load or store is in flight.
// The optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        regM_i_valid,
  input  logic        regM_i_mem_ren,
  input  logic        regM_i_mem_wen,
  input  logic [1:0]  regM_i_mem_size,
  input  logic        regM_i_mem_unsigned,
  input  logic [31:0] regM_i_valE,
  input  logic [31:0] regM_i_valB,
  output logic        mem_o_req_valid,
  input  logic        mem_i_req_ready,
  output logic [31:0] mem_o_addr,
  output logic        mem_o_wen,
  output logic [31:0] mem_o_wdata,
  output logic [3:0]  mem_o_wmask,
  input  logic        mem_i_rvalid,
  input  logic [31:0] mem_i_rdata,
  output logic [31:0] memory_o_valM,
  output logic        memory_o_stall,
  output logic        memory_o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] valm_q, valm_d;

  logic        is_mem;
  logic [1:0]  offset;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        in_req;

  assign is_mem = regM_i_valid & (regM_i_mem_ren | regM_i_mem_wen);
  assign offset = regM_i_valE[1:0];
  assign in_req = (state_q == S_REQ);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misaligned = 1'b0;
    case (regM_i_mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = offset[0];
      default: misaligned = (offset != 2'b00);
    endcase
  end

  // Flag is raised only for the DONE cycle that follows a trapped access.
  always_comb begin
    misalign_d = (state_q == S_IDLE) & is_mem & misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign memory_o_misalign = misalign_q;
`else
  assign misaligned        = 1'b0;
  assign memory_o_misalign = 1'b0;
`endif

  always_comb begin
    ld_byte = mem_i_rdata[7:0];
    case (offset)
      2'b00: ld_byte = mem_i_rdata[7:0];
      2'b01: ld_byte = mem_i_rdata[15:8];
      2'b10: ld_byte = mem_i_rdata[23:16];
      2'b11: ld_byte = mem_i_rdata[31:24];
      default: ld_byte = mem_i_rdata[7:0];
    endcase
    ld_half = offset[1] ? mem_i_rdata[31:16] : mem_i_rdata[15:0];

    ld_fmt = mem_i_rdata;
    case (regM_i_mem_size)
      2'b00:   ld_fmt = {{24{~regM_i_mem_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{~regM_i_mem_unsigned & ld_half[15]}}, ld_half};
      default: ld_fmt = mem_i_rdata;
    endcase
  end

  // Store data is replicated across lanes so the mask alone selects the bytes written.
  always_comb begin
    st_wdata = regM_i_valB;
    st_wmask = 4'b1111;
    case (regM_i_mem_size)
      2'b00: begin
        st_wdata = {4{regM_i_valB[7:0]}};
        st_wmask = 4'b0001 << offset;
      end
      2'b01: begin
        st_wdata = {2{regM_i_valB[15:0]}};
        st_wmask = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = regM_i_valB;
        st_wmask = 4'b1111;
      end
    endcase
  end

  assign mem_o_addr      = {regM_i_valE[31:2], 2'b00};
  assign mem_o_wdata     = st_wdata;
  assign mem_o_req_valid = in_req;
  assign mem_o_wen       = in_req & regM_i_mem_wen;
  assign mem_o_wmask     = (in_req & regM_i_mem_wen) ? st_wmask : 4'b0000;
  assign memory_o_valM   = valm_q;

  always_comb begin
    state_d        = state_q;
    valm_d         = valm_q;
    memory_o_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          memory_o_stall = 1'b1;
          if (misaligned) begin
            state_d = S_DONE;
            valm_d  = 32'h0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        memory_o_stall = 1'b1;
        if (mem_i_req_ready) begin
          state_d = regM_i_mem_wen ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        memory_o_stall = 1'b1;
        if (mem_i_rvalid) begin
          valm_d  = ld_fmt;
          state_d = S_DONE;
        end
      end
      // The M register advances on this edge, so IDLE never re-triggers on the same access.
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valm_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      valm_q  <= valm_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level reference model.
// Expectations follow MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        regm_valid;
  logic        regm_ren;
  logic        regm_wen;
  logic [1:0]  regm_size;
  logic        regm_unsigned;
  logic [31:0] regm_vale;
  logic [31:0] regm_valb;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] valm;
  logic        stall;
  logic        misalign;

  int          checks;
  int          errors;
  logic [31:0] ref_valm;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  mem_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .regM_i_valid        (regm_valid),
    .regM_i_mem_ren      (regm_ren),
    .regM_i_mem_wen      (regm_wen),
    .regM_i_mem_size     (regm_size),
    .regM_i_mem_unsigned (regm_unsigned),
    .regM_i_valE         (regm_vale),
    .regM_i_valB         (regm_valb),
    .mem_o_req_valid     (req_valid),
    .mem_i_req_ready     (req_ready),
    .mem_o_addr          (addr),
    .mem_o_wen           (wen),
    .mem_o_wdata         (wdata),
    .mem_o_wmask         (wmask),
    .mem_i_rvalid        (rvalid),
    .mem_i_rdata         (rdata),
    .memory_o_valM       (valm),
    .memory_o_stall      (stall),
    .memory_o_misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference formatting: pick the lane arithmetically, then sign-extend by wraparound.
  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] vale, input logic [31:0] word);
    logic [31:0] v;
    int          off;
    off = int'(vale % 4);
    if (size == 2'd0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (word >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] valb);
    if (size == 2'd0) return (valb & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (valb & 32'hFFFF) * 32'h0001_0001;
    return valb;
  endfunction

  function automatic logic [31:0] model_wmask(input logic [1:0] size, input logic [31:0] vale);
    int off;
    off = int'(vale % 4);
    if (size == 2'd0) return 32'd1 << off;
    if (size == 2'd1) return 32'd3 << (2 * (off / 2));
    return 32'd15;
  endfunction

  function automatic bit model_trap(input logic [1:0] size, input logic [31:0] vale);
    if (!TRAP_EN) return 1'b0;
    if (size == 2'd1) return (vale % 2) != 0;
    if (size >= 2'd2) return (vale % 4) != 0;
    return 1'b0;
  endfunction

  // Runs one M-stage slot from IDLE through DONE, checking every cycle.
  task automatic applyStimulus(input bit valid, input bit ren, input bit st, input logic [1:0] size,
                               input bit uns, input logic [31:0] vale, input logic [31:0] valb,
                               input logic [31:0] load_word, input int ready_delay, input int rvalid_delay);
    bit          is_mem;
    logic [31:0] exp_addr;
    is_mem   = valid && (ren || st);
    exp_addr = vale - (vale % 4);

    @(negedge clk);
    regm_valid    = valid;
    regm_ren      = ren;
    regm_wen      = st;
    regm_size     = size;
    regm_unsigned = uns;
    regm_vale     = vale;
    regm_valb     = valb;
    req_ready     = 1'($urandom % 2);
    rvalid        = 1'($urandom % 2);
    rdata         = $urandom;
    #1;
    checkOutput("first_stall", stall, is_mem);
    checkOutput("first_req_valid", req_valid, 0);
    checkOutput("first_wmask", wmask, 0);
    checkOutput("first_wen", wen, 0);
    checkOutput("first_valm", valm, ref_valm);
    checkOutput("first_misalign", misalign, 0);
    if (!is_mem) return;

    if (model_trap(size, vale)) begin
      @(negedge clk);
      req_ready = 1'($urandom % 2);
      rvalid    = 1'($urandom % 2);
      #1;
      ref_valm = 32'h0;
      checkOutput("trap_stall", stall, 0);
      checkOutput("trap_req_valid", req_valid, 0);
      checkOutput("trap_misalign", misalign, 1);
      checkOutput("trap_valm", valm, ref_valm);
      return;
    end

    for (int c = 0; c <= ready_delay; c++) begin
      @(negedge clk);
      req_ready = (c == ready_delay);
      rvalid    = 1'($urandom % 2);
      rdata     = $urandom;
      #1;
      checkOutput("req_valid", req_valid, 1);
      checkOutput("req_addr", addr, exp_addr);
      checkOutput("req_wen", wen, st);
      checkOutput("req_stall", stall, 1);
      checkOutput("req_valm", valm, ref_valm);
      checkOutput("req_misalign", misalign, 0);
      if (st) begin
        checkOutput("req_wdata", wdata, model_wdata(size, valb));
        checkOutput("req_wmask", wmask, model_wmask(size, vale));
      end
    end

    if (!st) begin
      for (int c = 1; c <= rvalid_delay; c++) begin
        @(negedge clk);
        req_ready = 1'($urandom % 2);
        rvalid    = (c == rvalid_delay);
        rdata     = (c == rvalid_delay) ? load_word : $urandom;
        #1;
        checkOutput("wait_stall", stall, 1);
        checkOutput("wait_req_valid", req_valid, 0);
        checkOutput("wait_wmask", wmask, 0);
        checkOutput("wait_valm", valm, ref_valm);
      end
      ref_valm = model_load(size, uns, vale, load_word);
    end

    @(negedge clk);
    req_ready = 1'($urandom % 2);
    rvalid    = 1'($urandom % 2);
    rdata     = $urandom;
    #1;
    checkOutput("done_stall", stall, 0);
    checkOutput("done_req_valid", req_valid, 0);
    checkOutput("done_wen", wen, 0);
    checkOutput("done_valm", valm, ref_valm);
    checkOutput("done_misalign", misalign, 0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    ref_valm      = 32'h0;
    rst           = 1'b1;
    regm_valid    = 1'b0;
    regm_ren      = 1'b0;
    regm_wen      = 1'b0;
    regm_size     = 2'b00;
    regm_unsigned = 1'b0;
    regm_vale     = 32'h0;
    regm_valb     = 32'h0;
    req_ready     = 1'b0;
    rvalid        = 1'b0;
    rdata         = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_valm", valm, 0);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_req_valid", req_valid, 0);
    checkOutput("reset_misalign", misalign, 0);
    checkOutput("reset_wmask", wmask, 0);
    @(negedge clk);
    rst = 1'b0;

    // LB from the top byte, immediate ready, data one cycle later.
    applyStimulus(1, 1, 0, 2'd0, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1);
    checkOutput("lb_result", valm, 32'hFFFF_FF80);

    // Reset while waiting for load data; the late response must be dropped.
    @(negedge clk);
    regm_valid = 1'b1; regm_ren = 1'b1; regm_wen = 1'b0;
    regm_size  = 2'd2; regm_vale = 32'h0000_3000;
    req_ready  = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #1;
    checkOutput("rst_wait_stall", stall, 1);
    rst = 1'b1;
    regm_valid = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    #1;
    ref_valm = 32'h0;
    checkOutput("rst_wait_valm", valm, ref_valm);
    checkOutput("rst_wait_stall_after", stall, 0);
    checkOutput("rst_wait_req_valid", req_valid, 0);
    checkOutput("rst_wait_misalign", misalign, 0);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    checkOutput("rst_late_rvalid_valm", valm, ref_valm);

    // SH to the upper half, then LW with a slow bus, then a misaligned LW.
    applyStimulus(1, 0, 1, 2'd1, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 1);
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h0000_4000, 32'h0, 32'h1234_5678, 4, 2);
    checkOutput("lw_slow_result", valm, 32'h1234_5678);
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h0000_1001, 32'h0, 32'hCAFE_F00D, 1, 1);
    checkOutput("lw_misaligned_result", valm, TRAP_EN ? 32'h0 : 32'hCAFE_F00D);

    for (int i = 0; i < 200; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      applyStimulus(($urandom % 8) != 0, op == 1, op == 2, 2'($urandom_range(0, 3)),
                    1'($urandom % 2), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  clock; all state on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 regM_i_valid  in  1  M-stage slot holds a real instruction.
REQ-004 regM_i_mem_ren  in  1  load.
REQ-005 regM_i_mem_wen  in  1  store; never set together with ren.
REQ-006 regM_i_mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 regM_i_mem_unsigned  in  1  zero-extend load (LBU/LHU).
REQ-008 regM_i_valE  in  32  effective address.
REQ-009 regM_i_valB  in  32  store data.
REQ-010 mem_o_req_valid  out  1  bus request valid.
REQ-011 mem_i_req_ready  in  1  bus accepts request.
REQ-012 mem_o_addr  out  32  word address {valE[31:2],2'b00}.
REQ-013 mem_o_wen  out  1  request is a store.
REQ-014 mem_o_wdata  out  32  lane-replicated store data.
REQ-015 mem_o_wmask  out  4  byte enables.
REQ-016 mem_i_rvalid  in  1  load data valid.
REQ-017 mem_i_rdata  in  32  load word.
REQ-018 memory_o_valM  out  32  registered, formatted load result; feeds W-register valM input.
REQ-019 memory_o_stall  out  1  freeze PC/F/D/E/M registers.
REQ-020 memory_o_misalign  out  1  misaligned-access flag.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-022 IDLE: valid&(ren|wen) -> REQ, stall=1 that cycle; else stay, stall=0.
REQ-023 REQ: req_valid=1, addr/wen/wdata/wmask stable; req_ready=1 -> store: DONE, load: WAIT; else stay; stall=1.
REQ-024 WAIT: stall=1; rvalid=1 -> capture formatted rdata into valM, -> DONE.
REQ-025 DONE: stall=0, valM stable; -> IDLE unconditionally (M register advances at this edge, no re-trigger).
REQ-026 Non-memory instruction: zero added latency; valM holds previous value.
REQ-027 Load format: byte lane valE[1:0], half lane valE[1]; sign-extend unless unsigned; word passthrough.
REQ-028 Store: byte wdata={4{b}}, wmask=0001<<valE[1:0]; half wdata={2{h}}, wmask=0011<<{valE[1],0}; word wmask=1111.
REQ-029 rvalid outside WAIT ignored; rvalid same cycle as req_ready ignored (data returns earliest next cycle).
REQ-030 req_valid, wen, wmask = 0 outside REQ.

Reset
REQ-031 rst forces IDLE, valM=0, req_valid=0, stall=0, misalign=0, including mid-REQ/WAIT; in-flight response discarded.

Configuration
REQ-032 Macro MEM_MISALIGN_TRAP_EN defined: half with valE[0]=1 or word with valE[1:0]!=0 -> IDLE->DONE, no bus request, stall=1 one cycle, in DONE misalign=1, valM=0.
REQ-033 Macro undefined: misalign tied 0; half uses valE[1] only, word ignores valE[1:0]; access proceeds normally.

Verification
REQ-034 LB valE=0x1003, rdata=0x80FF_1234, ready immediate, rvalid 1 cycle later -> valM=0xFFFF_FF80, stall high 3 cycles.
REQ-035 SH valE=0x2002, valB=0x0000_ABCD -> wdata=0xABCD_ABCD, wmask=1100, wen=1, no WAIT.
REQ-036 LW with req_ready low 4 cycles -> req_valid and addr stable all 4 cycles, stall held until DONE.
REQ-037 rst asserted in WAIT, rvalid next cycle -> IDLE, valM=0, stall=0, late rvalid ignored.
REQ-038 MEM_MISALIGN_TRAP_EN: LW valE=0x1001 -> no req_valid, misalign=1 one cycle, valM=0; undefined: request to 0x1000.
